cpu_ctrl_fsm: RTL and testbench
===============================

CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

Interface
REQ-001 Parameter: MEM_WAIT_MAX, default 15; maximum cycles MEM waits for Mem_Ready before forcing completion.
REQ-002 Clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Reset_N  input  1  synchronous, active-low reset.
REQ-004 Run  input  1  level; 1 = execute instructions, 0 = stop at next instruction boundary.
REQ-005 Instruction  input  8  IMEM read data for PC, combinational.
REQ-006 Mem_Ready  input  1  DMEM access completes this cycle.
REQ-007 PC  output  8  instruction address, driven to IMEM read address.
REQ-008 IR  output  8  latched instruction.
REQ-009 Reg_Write, Mem_Read, Mem_Write, ALU_Src, Mem_To_Reg  output  1 each  datapath controls.
REQ-010 Write_Reg  output  2  destination register number.
REQ-011 State  output  3  current FSM state encoding.
REQ-012 Halted  output  1  sticky; self-jump executed.
REQ-013 Instr_Count  output  16  retired-instruction counter.

Function
REQ-014 Encoding: [7:6] op, [5:4] rs, [3:2] rt, [1:0] rd or imm2; op 00 add, 01 lw, 10 sw, 11 j with signed offset [5:0].
REQ-015 States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5; encodings 6 and 7 are illegal and return to IDLE next cycle.
REQ-016 IDLE->FETCH when Run=1 and Halted=0; otherwise the FSM holds IDLE.
REQ-017 FETCH: IR <= Instruction; next state DECODE.
REQ-018 DECODE->EXEC unconditionally; controls are decoded from IR.
REQ-019 EXEC: add->WB; lw, sw->MEM; j->FETCH, or IDLE if Run=0.
REQ-020 MEM: stays until Mem_Ready=1 or the wait counter reaches MEM_WAIT_MAX; then lw->WB; sw->FETCH, or IDLE if Run=0.
REQ-021 WB->FETCH, or IDLE if Run=0.
REQ-022 Cycles per instruction with Mem_Ready=1 in the first MEM cycle: add 4, lw 5, sw 4, j 3.
REQ-023 PC update: non-jump instructions set PC <= PC+1 on leaving the final state; j sets PC <= PC + 1 + sext(IR[5:0]) in EXEC; all PC arithmetic is modulo 256.
REQ-024 Wrap: PC=255 followed by a non-jump gives PC=0, with no flag.
REQ-025 Self-jump (offset 6'b111111): PC is unchanged, Halted<=1, and the next state is IDLE regardless of Run.
REQ-026 Controls: Mem_Read=1 only in MEM for lw; Mem_Write=1 only in MEM for sw; Reg_Write=1 only in WB.
REQ-027 ALU_Src=1 for lw/sw in EXEC and MEM; Mem_To_Reg=1 for lw in WB; all controls are 0 in every other state.
REQ-028 Write_Reg: rd (IR[1:0]) for add, rt (IR[3:2]) for lw; 0 otherwise.
REQ-029 Instr_Count increments by 1 when each instruction retires, including j; it wraps at 65535 to 0.
REQ-030 Run falling mid-instruction does not abort it; the current instruction completes and then the FSM enters IDLE.
REQ-031 Mem_Ready outside MEM is ignored.

Reset
REQ-032 When Reset_N=0 at a rising edge: State=IDLE, PC=0, IR=0, Halted=0, Instr_Count=0, MEM wait counter=0, all controls 0.
REQ-033 Reset asserted in any state, including MEM mid-wait, takes effect at that edge with no memory write issued afterward.
REQ-034 Halted clears only by reset.

Structure
REQ-035 Package cpu_pkg holds the opcode constants (OP_ADD, OP_LW, OP_SW, OP_J), the state encodings, and the instruction field positions.
REQ-036 One sub-module, ctrl_decode, maps op and state to the control outputs combinationally; PC, IR, counters and the FSM stay in cpu_ctrl_fsm.

Verification
REQ-037 Reset, Run=1, IMEM {0x44, 0x49, 0x18, 0x89} (lw s1,0(s0); lw s2,1(s0); add s0,s1,s2; sw s2,1(s0)), Mem_Ready=1 -> PC 0,1,2,3,4; Instr_Count=4 after 19 cycles; Reg_Write pulses with Write_Reg 1, 2, 0; Mem_Write pulses once.
REQ-038 j with offset 6'b111110 at PC=4 -> PC=3 after EXEC; j 6'b111111 at PC=4 -> Halted=1, State=IDLE, PC stays 4, and Run=1 does not restart.
REQ-039 lw with Mem_Ready held 0 -> 15 MEM cycles, then WB; Mem_Ready=1 on the third MEM cycle -> WB on the next edge.
REQ-040 Run dropped during MEM of sw -> sw completes and the FSM enters IDLE with PC advanced by 1.
REQ-041 Reset_N=0 during MEM of sw -> Mem_Write=0 from the next cycle and all outputs at reset values; add at PC=255 -> PC=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the multi-cycle CPU controller: opcode constants,
// FSM state encodings, the instruction field layout and the jump-offset
// sign-extension helper. Imported by cpu_ctrl_fsm and ctrl_decode.
// No ports (package).
package cpu_pkg;

  // Opcodes held in instruction bits [7:6]
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  // FSM states; encodings 6 and 7 are unused and recover to IDLE
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_e;

  // Instruction layout: [7:6] op, [5:4] rs, [3:2] rt, [1:0] rd / imm2.
  // For j the signed offset occupies [5:0] = {rs, rt, rd}.
  typedef struct packed {
    logic [1:0] op;
    logic [1:0] rs;
    logic [1:0] rt;
    logic [1:0] rd;
  } instr_t;

  // A jump offset of -1 lands back on the jump itself, which halts the core
  localparam logic [5:0] SELF_JUMP_OFF = 6'b111111;

  // Sign-extend a 6-bit jump offset to PC width
  function automatic logic [7:0] sextOffset(input logic [5:0] off);
    return {{2{off[5]}}, off};
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_decode.sv
// ctrl_decode
// Purely combinational map from (opcode, FSM state) to datapath controls.
// Every control is zero unless the state/opcode pair calls for it.
// Ports:
//   op_i        opcode of the latched instruction
//   rt_i, rd_i  register fields of the latched instruction
//   state_i     current FSM state
//   regWrite_o, memRead_o, memWrite_o, aluSrc_o, memToReg_o  controls
//   writeReg_o  destination register (only meaningful while writing back)
module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [1:0] op_i,
  input  logic [1:0] rt_i,
  input  logic [1:0] rd_i,
  input  state_e     state_i,
  output logic       regWrite_o,
  output logic       memRead_o,
  output logic       memWrite_o,
  output logic       aluSrc_o,
  output logic       memToReg_o,
  output logic [1:0] writeReg_o
);

  logic isLoad;
  logic isStore;
  logic isAdd;

  assign isLoad  = (op_i == OP_LW);
  assign isStore = (op_i == OP_SW);
  assign isAdd   = (op_i == OP_ADD);

  // Controls default low; only EXEC, MEM and WB ever raise anything.
  // The destination register is presented only alongside Reg_Write so that
  // it reads as zero in every state where nothing is being written.
  always_comb begin
    regWrite_o = 1'b0;
    memRead_o  = 1'b0;
    memWrite_o = 1'b0;
    aluSrc_o   = 1'b0;
    memToReg_o = 1'b0;
    writeReg_o = 2'b00;
    case (state_i)
      ST_EXEC: begin
        aluSrc_o = isLoad | isStore;
      end
      ST_MEM: begin
        aluSrc_o   = isLoad | isStore;
        memRead_o  = isLoad;
        memWrite_o = isStore;
      end
      ST_WB: begin
        regWrite_o = isLoad | isAdd;
        memToReg_o = isLoad;
        if (isLoad) begin
          writeReg_o = rt_i;
        end else if (isAdd) begin
          writeReg_o = rd_i;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm
// Multi-cycle controller for a tiny 8-bit CPU: sequences
// IDLE/FETCH/DECODE/EXEC/MEM/WB, owns PC, IR, the halt flag, the retired
// instruction counter and the bounded memory-wait counter.
// Ports:
//   Clk, Reset_N   clock and synchronous active-low reset
//   Run            level; 0 stops at the next instruction boundary
//   Instruction    IMEM read data at address PC
//   Mem_Ready      DMEM access completes this cycle (used only in MEM)
//   PC, IR         instruction address / latched instruction
//   Reg_Write, Mem_Read, Mem_Write, ALU_Src, Mem_To_Reg, Write_Reg  controls
//   State          current state encoding
//   Halted         sticky, set by a self-jump, cleared only by reset
//   Instr_Count    retired-instruction counter (wraps)
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
)
(
  input  logic        Clk,
  input  logic        Reset_N,
  input  logic        Run,
  input  logic [7:0]  Instruction,
  input  logic        Mem_Ready,
  output logic [7:0]  PC,
  output logic [7:0]  IR,
  output logic        Reg_Write,
  output logic        Mem_Read,
  output logic        Mem_Write,
  output logic        ALU_Src,
  output logic        Mem_To_Reg,
  output logic [1:0]  Write_Reg,
  output logic [2:0]  State,
  output logic        Halted,
  output logic [15:0] Instr_Count
);

  localparam int WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  state_e            state_q, state_d;
  logic [7:0]        pc_q, pc_d;
  instr_t            ir_q, ir_d;
  logic              halted_q, halted_d;
  logic [15:0]       count_q, count_d;
  logic [WAIT_W-1:0] memWait_q, memWait_d;

  logic              memDone;
  logic              jumpSelf;

  // The wait counter holds the number of MEM cycles already spent, so the
  // cycle in which it shows MEM_WAIT_MAX-1 is the last one allowed.
  assign memDone  = Mem_Ready | (memWait_q >= WAIT_LAST);
  assign jumpSelf = ({ir_q.rs, ir_q.rt, ir_q.rd} == SELF_JUMP_OFF);

  // Next-state, PC, IR, halt, retire-count and wait-counter logic. Every
  // register holds by default; an instruction retires (PC and count move)
  // on the edge that leaves its final state. Run is only consulted at
  // instruction boundaries so a falling Run never aborts an instruction.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    halted_d  = halted_q;
    count_d   = count_q;
    memWait_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (Run && !halted_q) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        ir_d    = instr_t'(Instruction);
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (ir_q.op)
          OP_ADD: state_d = ST_WB;
          OP_LW,
          OP_SW:  state_d = ST_MEM;
          OP_J: begin
            // A self-jump computes PC+1-1, leaving PC where it was
            pc_d    = pc_q + 8'd1 + sextOffset({ir_q.rs, ir_q.rt, ir_q.rd});
            count_d = count_q + 16'd1;
            if (jumpSelf) begin
              halted_d = 1'b1;
              state_d  = ST_IDLE;
            end else begin
              state_d  = Run ? ST_FETCH : ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
      ST_MEM: begin
        if (memDone) begin
          if (ir_q.op == OP_LW) begin
            state_d = ST_WB;
          end else begin
            pc_d    = pc_q + 8'd1;
            count_d = count_q + 16'd1;
            state_d = Run ? ST_FETCH : ST_IDLE;
          end
        end else begin
          memWait_d = memWait_q + WAIT_W'(1);
        end
      end
      ST_WB: begin
        pc_d    = pc_q + 8'd1;
        count_d = count_q + 16'd1;
        state_d = Run ? ST_FETCH : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset; reset
  // wins in every state, including a pending memory wait.
  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      state_q   <= ST_IDLE;
      pc_q      <= 8'd0;
      ir_q      <= '0;
      halted_q  <= 1'b0;
      count_q   <= 16'd0;
      memWait_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      halted_q  <= halted_d;
      count_q   <= count_d;
      memWait_q <= memWait_d;
    end
  end

  ctrl_decode uDecode (
    .op_i       (ir_q.op),
    .rt_i       (ir_q.rt),
    .rd_i       (ir_q.rd),
    .state_i    (state_q),
    .regWrite_o (Reg_Write),
    .memRead_o  (Mem_Read),
    .memWrite_o (Mem_Write),
    .aluSrc_o   (ALU_Src),
    .memToReg_o (Mem_To_Reg),
    .writeReg_o (Write_Reg)
  );

  assign PC          = pc_q;
  assign IR          = ir_q;
  assign State       = state_q;
  assign Halted      = halted_q;
  assign Instr_Count = count_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm
// Directed bench for cpu_ctrl_fsm. An IMEM array answers PC combinationally.
// Stimulus pushes expected retirements, register writes and memory writes
// into queues; a monitor pops and compares whenever the DUT shows the event.
module tb_cpu_ctrl_fsm;

  logic        Clk = 1'b0;
  logic        Reset_N;
  logic        Run;
  logic [7:0]  Instruction;
  logic        Mem_Ready;
  logic [7:0]  PC;
  logic [7:0]  IR;
  logic        Reg_Write;
  logic        Mem_Read;
  logic        Mem_Write;
  logic        ALU_Src;
  logic        Mem_To_Reg;
  logic [1:0]  Write_Reg;
  logic [2:0]  State;
  logic        Halted;
  logic [15:0] Instr_Count;

  logic [7:0]  imem [0:255];

  int nChecks = 0;
  int nFails  = 0;

  // Scoreboard queues
  int expRetCnt[$];
  int expRetPc[$];
  int expWrReg[$];
  int expWrMtr[$];
  int expMemPc[$];

  logic rstSampled = 1'b0;

  cpu_ctrl_fsm #(.MEM_WAIT_MAX(15)) dut (
    .Clk         (Clk),
    .Reset_N     (Reset_N),
    .Run         (Run),
    .Instruction (Instruction),
    .Mem_Ready   (Mem_Ready),
    .PC          (PC),
    .IR          (IR),
    .Reg_Write   (Reg_Write),
    .Mem_Read    (Mem_Read),
    .Mem_Write   (Mem_Write),
    .ALU_Src     (ALU_Src),
    .Mem_To_Reg  (Mem_To_Reg),
    .Write_Reg   (Write_Reg),
    .State       (State),
    .Halted      (Halted),
    .Instr_Count (Instr_Count)
  );

  always #5 Clk = ~Clk;

  assign Instruction = imem[PC];

  always @(posedge Clk) rstSampled <= Reset_N;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstN, input logic run, input logic rdy);
    Reset_N   = rstN;
    Run       = run;
    Mem_Ready = rdy;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " State"}, State, 0);
    checkOutput({tag, " PC"}, PC, 0);
    checkOutput({tag, " IR"}, IR, 0);
    checkOutput({tag, " Halted"}, Halted, 0);
    checkOutput({tag, " Instr_Count"}, Instr_Count, 0);
    checkOutput({tag, " controls"},
                {Reg_Write, Mem_Read, Mem_Write, ALU_Src, Mem_To_Reg, Write_Reg}, 0);
  endtask

  task automatic pushRetire(input int cnt, input int pc);
    expRetCnt.push_back(cnt);
    expRetPc.push_back(pc);
  endtask

  task automatic pushWrite(input int wr, input int mtr);
    expWrReg.push_back(wr);
    expWrMtr.push_back(mtr);
  endtask

  // Monitor: samples on the falling edge, ignoring cycles that followed a
  // reset edge, and compares each retirement / register write / memory
  // write start against the head of its queue.
  initial begin : monitor
    logic [15:0] prevCount;
    logic        prevMemW;
    prevCount = 16'd0;
    prevMemW  = 1'b0;
    forever begin
      @(negedge Clk);
      if (rstSampled === 1'b1) begin
        if (Instr_Count !== prevCount) begin
          if (expRetCnt.size() == 0) begin
            checkOutput("retire unexpected", Instr_Count, prevCount);
          end else begin
            checkOutput("retire Instr_Count", Instr_Count, expRetCnt.pop_front());
            checkOutput("retire PC", PC, expRetPc.pop_front());
          end
        end
        if (Reg_Write === 1'b1) begin
          if (expWrReg.size() == 0) begin
            checkOutput("regwrite unexpected", Reg_Write, 0);
          end else begin
            checkOutput("regwrite Write_Reg", Write_Reg, expWrReg.pop_front());
            checkOutput("regwrite Mem_To_Reg", Mem_To_Reg, expWrMtr.pop_front());
          end
        end
        if (Mem_Write === 1'b1 && prevMemW !== 1'b1) begin
          if (expMemPc.size() == 0) begin
            checkOutput("memwrite unexpected", Mem_Write, 0);
          end else begin
            checkOutput("memwrite PC", PC, expMemPc.pop_front());
          end
        end
      end
      prevCount = Instr_Count;
      prevMemW  = Mem_Write;
    end
  end

  initial begin : stimulus
    int memCycles;
    logic memWSeen;
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkResetValues("reset");

    // Four-instruction program: lw, lw, add, sw with immediate Mem_Ready
    imem[0] = 8'h44;
    imem[1] = 8'h49;
    imem[2] = 8'h18;
    imem[3] = 8'h89;
    pushRetire(1, 1); pushRetire(2, 2); pushRetire(3, 3); pushRetire(4, 4);
    pushWrite(1, 1); pushWrite(2, 1); pushWrite(0, 0);
    expMemPc.push_back(3);
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (18) tick();
    checkOutput("prog sw State", State, 4);
    checkOutput("prog sw Mem_Write", Mem_Write, 1);
    checkOutput("prog sw ALU_Src", ALU_Src, 1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("prog end State", State, 0);
    checkOutput("prog end PC", PC, 4);
    checkOutput("prog end Instr_Count", Instr_Count, 4);
    tick();
    checkOutput("prog idle hold", State, 0);

    // Backward jump by -2 from PC=4 lands on PC=3
    imem[4] = 8'hFE;
    pushRetire(5, 3);
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (3) tick();
    checkOutput("jump EXEC State", State, 3);
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("jump State", State, 0);
    checkOutput("jump PC", PC, 3);

    // add rd=3 with Run dropped mid-instruction still completes
    imem[3] = 8'h1B;
    pushRetire(6, 4);
    pushWrite(3, 0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (3) tick();
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("add WB State", State, 5);
    tick();
    checkOutput("add idle State", State, 0);
    checkOutput("add PC", PC, 4);

    // Self-jump halts; Run=1 must not restart
    imem[4] = 8'hFF;
    pushRetire(7, 4);
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (4) tick();
    checkOutput("halt Halted", Halted, 1);
    checkOutput("halt State", State, 0);
    checkOutput("halt PC", PC, 4);
    repeat (5) tick();
    checkOutput("halt hold State", State, 0);
    checkOutput("halt hold PC", PC, 4);
    checkOutput("halt hold Instr_Count", Instr_Count, 7);

    // Reset clears Halted; then lw with Mem_Ready held low times out
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkResetValues("reset after halt");
    imem[0] = 8'h44;
    imem[1] = 8'h49;
    pushRetire(1, 1); pushRetire(2, 2);
    pushWrite(1, 1); pushWrite(2, 1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (4) tick();
    checkOutput("lw MEM State", State, 4);
    checkOutput("lw MEM Mem_Read", Mem_Read, 1);
    checkOutput("lw MEM Mem_Write", Mem_Write, 0);
    memCycles = 1;
    while (State == 3'd4 && memCycles < 40) begin
      tick();
      if (State == 3'd4) memCycles++;
    end
    checkOutput("lw timeout MEM cycles", memCycles, 15);
    checkOutput("lw timeout State", State, 5);

    // Second lw: Mem_Ready arrives in its third MEM cycle
    repeat (6) tick();
    checkOutput("lw2 MEM3 State", State, 4);
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("lw2 WB State", State, 5);
    checkOutput("lw2 WB Reg_Write", Reg_Write, 1);
    tick();
    checkOutput("lw2 idle State", State, 0);
    checkOutput("lw2 PC", PC, 2);

    // Reset in the middle of a sw memory wait
    imem[2] = 8'h89;
    expMemPc.push_back(2);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (4) tick();
    checkOutput("sw wait Mem_Write", Mem_Write, 1);
    repeat (2) tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkResetValues("reset in MEM");
    applyStimulus(1'b1, 1'b0, 1'b0);
    memWSeen = 1'b0;
    repeat (5) begin
      tick();
      memWSeen = memWSeen | Mem_Write;
    end
    checkOutput("post-reset Mem_Write", memWSeen, 0);

    // Jump from 0 to 255, then add at 255 wraps PC to 0
    imem[0]   = 8'hFE;
    imem[255] = 8'h1E;
    pushRetire(1, 255); pushRetire(2, 0);
    pushWrite(2, 0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (6) tick();
    checkOutput("wrap EXEC State", State, 3);
    checkOutput("wrap PC at 255", PC, 255);
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (2) tick();
    checkOutput("wrap State", State, 0);
    checkOutput("wrap PC", PC, 0);
    checkOutput("wrap Instr_Count", Instr_Count, 2);

    tick();
    checkOutput("retire queue drained", expRetCnt.size(), 0);
    checkOutput("regwrite queue drained", expWrReg.size(), 0);
    checkOutput("memwrite queue drained", expMemPc.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
